// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer: op codes, widths, FSM states.
package muldiv_ctrl_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_STEPS = 32;

  localparam logic [2:0] MDOP_NOP   = 3'b000;
  localparam logic [2:0] MDOP_MULT  = 3'b001;
  localparam logic [2:0] MDOP_MULTU = 3'b010;
  localparam logic [2:0] MDOP_DIV   = 3'b011;
  localparam logic [2:0] MDOP_DIVU  = 3'b100;
  localparam logic [2:0] MDOP_MTHI  = 3'b101;
  localparam logic [2:0] MDOP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // Magnitude of a value that is only treated as two's complement for signed ops.
  function automatic logic [MD_XLEN-1:0] md_mag(input logic [MD_XLEN-1:0] v, input logic sgn);
    return (sgn && v[MD_XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide on a 64-bit accumulator.
module muldiv_step
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic              is_div_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              qbit_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] diff;

  // Multiply: upper half accumulates, multiplier shifts out of the lower half.
  // Divide: upper half is the partial remainder, dividend shifts in from the lower half.
  always_comb begin
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, opnd_i};
    diff   = acc_i[2*XLEN-1:XLEN-1] - {1'b0, opnd_i};
    qbit_o = 1'b0;
    acc_o  = '0;
    if (is_div_i) begin
      qbit_o = ~diff[XLEN];
      acc_o  = {(qbit_o ? diff[XLEN-1:0] : acc_i[2*XLEN-2:XLEN-1]), acc_i[XLEN-2:0], 1'b0};
    end else if (acc_i[0]) begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end else begin
      acc_o = {1'b0, acc_i[2*XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; stalls the pipeline while an op is in flight.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            rd_req,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(STEPS);

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              is_div_q, is_div_d;
  logic              neg_p_q, neg_p_d;
  logic              neg_r_q, neg_r_d;
  logic              bzero_q, bzero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [2*XLEN-1:0] step_acc;
  logic              step_q;
  logic              op_signed, op_div, op_calc;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (step_acc),
    .qbit_o   (step_q)
  );

  assign op_signed = (op == MDOP_MULT) || (op == MDOP_DIV);
  assign op_div    = (op == MDOP_DIV)  || (op == MDOP_DIVU);
  assign op_calc   = op_signed || op_div || (op == MDOP_MULTU);

  assign prod = neg_p_q ? -acc_q : acc_q;
  assign quot = neg_p_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem  = neg_r_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    bzero_d  = bzero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          if (op_calc) begin
            acc_d    = {{XLEN{1'b0}}, md_mag(A, op_signed)};
            opnd_d   = md_mag(B, op_signed);
            a_raw_d  = A;
            is_div_d = op_div;
            neg_p_d  = op_signed & (A[XLEN-1] ^ B[XLEN-1]);
            neg_r_d  = op_signed & A[XLEN-1];
            bzero_d  = (B == '0);
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = ST_CALC;
          end else if (op == MDOP_MTHI) begin
            hi_d = A;
          end else if (op == MDOP_MTLO) begin
            lo_d = A;
          end
        end
      end
      ST_CALC: begin
        acc_d = {step_acc[2*XLEN-1:1], step_acc[0] | step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(STEPS-1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (!is_div_q) begin
          hi_d = prod[2*XLEN-1:XLEN];
          lo_d = prod[XLEN-1:0];
        end else if (bzero_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    // A squash wins over the final write-back.
    if (flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      bzero_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_raw_q  <= a_raw_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      bzero_q  <= bzero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = busy_q & (start | rd_req);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed vector table plus hand sequences for stall, MTHI/MTLO, flush and mid-op reset.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a_i = '0, b_i = '0;
  logic        rd_req = 1'b0;
  logic        flush = 1'b0;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[11];

  muldiv_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .A      (a_i),
    .B      (b_i),
    .rd_req (rd_req),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Counts busy cycles from the first negedge after the accepting edge; ends in the done cycle.
  task automatic wait_done(input string nm, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, n, 33);
    chk({nm, " done"}, {31'b0, done}, 1);
    chk({nm, " hi"}, hi, exp_hi);
    chk({nm, " lo"}, lo, exp_lo);
    @(negedge clk);
    chk({nm, " done_drop"}, {31'b0, done}, 0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; a_i = a; b_i = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    int n, bad;
    vecs[0]  = '{3'b001, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'b100, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[4]  = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'b011, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[6]  = '{3'b100, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[7]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[8]  = '{3'b100, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999};
    vecs[9]  = '{3'b011, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[10] = '{3'b010, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

    #2;
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset done", {31'b0, done}, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // DIVU 100/7 while the next op (MULTU 3x5) and a read are held against it.
    @(negedge clk);
    start = 1'b1; op = 3'b100; a_i = 32'd100; b_i = 32'd7;
    @(posedge clk);
    #1 op = 3'b010; a_i = 32'd3; b_i = 32'd5; rd_req = 1'b1;
    n = 0; bad = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      if (!stall) bad++;
      n++;
      @(negedge clk);
    end
    chk("hold stall_missing", bad, 0);
    chk("hold busy_cycles", n, 33);
    chk("hold first hi", hi, 2);
    chk("hold first lo", lo, 14);
    chk("hold done", {31'b0, done}, 1);
    chk("hold stall_done_cycle", {31'b0, stall}, 0);
    @(posedge clk);
    #1 start = 1'b0; rd_req = 1'b0;
    wait_done("hold second", 32'd0, 32'd15);

    issue(3'b101, 32'hAA, 32'h0);
    @(negedge clk);
    chk("mthi hi", hi, 32'hAA);
    chk("mthi busy", {31'b0, busy}, 0);
    chk("mthi lo_kept", lo, 32'd15);
    issue(3'b110, 32'h55, 32'h0);
    @(negedge clk);
    chk("mtlo lo", lo, 32'h55);
    chk("mtlo hi_kept", hi, 32'hAA);

    // flush together with start in IDLE drops the MTHI.
    @(negedge clk);
    start = 1'b1; op = 3'b101; a_i = 32'h77; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush hi", hi, 32'hAA);
    chk("idle_flush busy", {31'b0, busy}, 0);

    issue(3'b001, 32'd2, 32'd3);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush busy", {31'b0, busy}, 0);
    n = 0;
    repeat (40) begin
      if (done || busy) n++;
      @(negedge clk);
    end
    chk("flush no_done", n, 0);
    chk("flush hi", hi, 32'hAA);
    chk("flush lo", lo, 32'h55);

    issue(3'b001, 32'd7, 32'd9);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst busy", {31'b0, busy}, 0);
    chk("midrst hi", hi, 0);
    chk("midrst lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(3'b001, 32'd2, 32'd3);
    wait_done("post_rst mult", 32'd0, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
